piso_frame_tx: RTL and testbench

//   Parallel-in serial-out frame transmitter. It produces the 1-bit serial stream consumed by the team's serial shift-register chain.

---
 rtl/piso_frame_tx.sv | 116 +++++++++++
 tb/tb_piso_frame_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_frame_tx.sv
// piso_frame_tx: parallel-in serial-out frame transmitter.
// Takes a WIDTH-bit word over valid/ready and shifts it out one bit per clk with a frame strobe.
module piso_frame_tx #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_frame,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | no frame active, ser_out at IDLE_LEVEL, ready for a word
  // SHIFT | frame active, ser_out carries bit cnt of the current word

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic             ser_out_nxt, frame_nxt, busy_nxt, done_nxt;
  logic             last_bit, xfer;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // sreg always holds the bits still to be sent, next bit at the head
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], IDLE_LEVEL} : {IDLE_LEVEL, w[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg      <= {WIDTH{IDLE_LEVEL}};
      ser_out   <= IDLE_LEVEL;
      ser_frame <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sreg      <= sreg_nxt;
      ser_out   <= ser_out_nxt;
      ser_frame <= frame_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    last_bit    = (state == SHIFT) && (cnt == CNT_LAST);
    din_ready   = (state == IDLE) || last_bit;
    xfer        = din_valid && din_ready;
    state_nxt   = state;
    cnt_nxt     = cnt;
    sreg_nxt    = sreg;
    ser_out_nxt = ser_out;
    frame_nxt   = ser_frame;
    busy_nxt    = busy;
    done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (xfer) begin
          state_nxt   = SHIFT;
          cnt_nxt     = '0;
          sreg_nxt    = advance(din);
          ser_out_nxt = head_bit(din);
          frame_nxt   = 1'b1;
          busy_nxt    = 1'b1;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          cnt_nxt     = cnt + 1'b1;
          sreg_nxt    = advance(sreg);
          ser_out_nxt = head_bit(sreg);
        end else begin
          done_nxt = 1'b1;
          if (xfer) begin
            // back-to-back: reload on the last-bit edge, frame stays high
            cnt_nxt     = '0;
            sreg_nxt    = advance(din);
            ser_out_nxt = head_bit(din);
          end else begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            ser_out_nxt = IDLE_LEVEL;
            frame_nxt   = 1'b0;
            busy_nxt    = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx: four configurations driven from one stimulus process,
// checked by a SIPO scoreboard monitor that recovers each word from ser_out/ser_frame.
module tb_piso_frame_tx;

  localparam int   NI      = 4;
  localparam int   WD [NI] = '{8, 8, 5, 16};
  localparam logic MSB[NI] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic IDL[NI] = '{1'b0, 1'b1, 1'b0, 1'b1};

  typedef struct packed {
    logic [15:0] w;
    int          c;
  } ent_t;

  logic        clk;
  logic        rst_n    [NI];
  logic [15:0] din      [NI];
  logic        din_valid[NI];
  logic        din_ready[NI];
  logic        ser_out  [NI];
  logic        ser_frame[NI];
  logic        busy     [NI];
  logic        done     [NI];

  ent_t        sb[NI][$];
  ent_t        cur[NI];
  logic [15:0] rx[NI];
  int          bitpos[NI];
  logic        done_due[NI];
  int          dcnt[NI];
  int          acc[NI];
  int          aborted[NI];
  int          cyc;
  int          tmo_cnt;
  int          vecs;
  int          errs;
  logic        end_req;
  logic        end_done;

  piso_frame_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_d0 (
    .clk(clk), .rst_n(rst_n[0]), .din(din[0][7:0]), .din_valid(din_valid[0]),
    .din_ready(din_ready[0]), .ser_out(ser_out[0]), .ser_frame(ser_frame[0]),
    .busy(busy[0]), .done(done[0]));

  piso_frame_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_d1 (
    .clk(clk), .rst_n(rst_n[1]), .din(din[1][7:0]), .din_valid(din_valid[1]),
    .din_ready(din_ready[1]), .ser_out(ser_out[1]), .ser_frame(ser_frame[1]),
    .busy(busy[1]), .done(done[1]));

  piso_frame_tx #(.WIDTH(5), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_d2 (
    .clk(clk), .rst_n(rst_n[2]), .din(din[2][4:0]), .din_valid(din_valid[2]),
    .din_ready(din_ready[2]), .ser_out(ser_out[2]), .ser_frame(ser_frame[2]),
    .busy(busy[2]), .done(done[2]));

  piso_frame_tx #(.WIDTH(16), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_d3 (
    .clk(clk), .rst_n(rst_n[3]), .din(din[3]), .din_valid(din_valid[3]),
    .din_ready(din_ready[3]), .ser_out(ser_out[3]), .ser_frame(ser_frame[3]),
    .busy(busy[3]), .done(done[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  function automatic logic [15:0] wmask(input int d);
    return 16'((32'd1 << WD[d]) - 32'd1);
  endfunction

  // called only from the monitor process
  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
    vecs = vecs + 1;
    if (got !== exp) begin
      errs = errs + 1;
      $display("FAIL %s inst%0d @cyc %0d: got %0h expected %0h", name, i, cyc, got, exp);
    end
  endtask

  // monitor: expected words come only from the stimulus-side queue
  initial begin
    vecs     = 0;
    errs     = 0;
    end_done = 1'b0;
    for (int i = 0; i < NI; i++) begin
      bitpos[i]   = 0;
      done_due[i] = 1'b0;
      dcnt[i]     = 0;
      aborted[i]  = 0;
      rx[i]       = '0;
      cur[i]      = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n[i]) begin
          chk("rst_ser_out", i, 32'(ser_out[i]), 32'(IDL[i]));
          chk("rst_frame", i, 32'(ser_frame[i]), 32'd0);
          chk("rst_busy", i, 32'(busy[i]), 32'd0);
          chk("rst_done", i, 32'(done[i]), 32'd0);
          if (bitpos[i] > 0) aborted[i] = aborted[i] + 1;
          bitpos[i]   = 0;
          done_due[i] = 1'b0;
        end else begin
          chk("done", i, 32'(done[i]), 32'(done_due[i]));
          if (done[i] === 1'b1) dcnt[i] = dcnt[i] + 1;
          done_due[i] = 1'b0;
          chk("din_ready", i, 32'(din_ready[i]),
              32'((ser_frame[i] !== 1'b1) || (bitpos[i] == WD[i] - 1)));
          chk("busy", i, 32'(busy[i]), 32'(ser_frame[i]));
          if (ser_frame[i] === 1'b1) begin
            if (bitpos[i] == 0) begin
              rx[i] = '0;
              chk("frame_has_word", i, 32'(sb[i].size() != 0), 32'd1);
              if (sb[i].size() != 0) begin
                cur[i] = sb[i].pop_front();
                chk("first_bit_cycle", i, 32'(cyc), 32'(cur[i].c));
              end
            end
            rx[i][MSB[i] ? (WD[i] - 1 - bitpos[i]) : bitpos[i]] = ser_out[i];
            bitpos[i] = bitpos[i] + 1;
            if (bitpos[i] == WD[i]) begin
              chk("word", i, 32'(rx[i] & wmask(i)), 32'(cur[i].w));
              bitpos[i]   = 0;
              done_due[i] = 1'b1;
            end
          end else begin
            chk("frame_gap", i, 32'(bitpos[i]), 32'd0);
            chk("idle_level", i, 32'(ser_out[i]), 32'(IDL[i]));
            bitpos[i] = 0;
          end
        end
      end
      if (end_req && !end_done) begin
        for (int i = 0; i < NI; i++) begin
          chk("done_count", i, 32'(dcnt[i]), 32'(acc[i] - aborted[i]));
          chk("sb_empty", i, 32'(sb[i].size()), 32'd0);
        end
        chk("handshake_timeouts", 0, 32'(tmo_cnt), 32'd0);
        end_done = 1'b1;
      end
    end
  end

  // entered at posedge+1; returns at posedge+1 just after the handshake edge
  task automatic send(input int d, input logic [15:0] w);
    int n;
    n            = 0;
    din[d]       = w & wmask(d);
    din_valid[d] = 1'b1;
    @(negedge clk);
    while (din_ready[d] !== 1'b1 && n < 64) begin
      @(negedge clk);
      n = n + 1;
    end
    if (din_ready[d] !== 1'b1) begin
      tmo_cnt      = tmo_cnt + 1;
      din_valid[d] = 1'b0;
    end else begin
      sb[d].push_back('{w: w & wmask(d), c: cyc + 1});
      acc[d] = acc[d] + 1;
      @(posedge clk);
      #1;
      din_valid[d] = 1'b0;
      din[d]       = 16'($urandom);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    end_req = 1'b0;
    tmo_cnt = 0;
    for (int i = 0; i < NI; i++) begin
      rst_n[i]     = 1'b0;
      din[i]       = '0;
      din_valid[i] = 1'b0;
      acc[i]       = 0;
    end
    idle_cycles(3);
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    idle_cycles(2);

    // single word MSB first, then LSB first
    send(0, 16'h00A5);
    idle_cycles(12);
    send(1, 16'h0001);
    idle_cycles(12);

    // back-to-back with valid held
    send(0, 16'h00A5);
    send(0, 16'h003C);
    idle_cycles(12);

    // valid with FF from bit 2 of a 00 frame; only the last-bit edge may take it
    send(0, 16'h0000);
    idle_cycles(2);
    send(0, 16'h00FF);
    idle_cycles(12);

    // async reset during bit 3 of FF, then a clean word
    send(0, 16'h00FF);
    idle_cycles(3);
    #2;
    rst_n[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    idle_cycles(1);
    send(0, 16'h005A);
    idle_cycles(12);

    // randomized back-to-back and gapped traffic on every configuration
    for (int d = 0; d < NI; d++) begin
      for (int k = 0; k < 30; k++) begin
        send(d, 16'($urandom));
        idle_cycles(int'($urandom_range(0, 2)));
      end
      idle_cycles(WD[d] + 4);
    end

    end_req = 1'b1;
    idle_cycles(4);
    if (!end_done) begin
      $display("FAIL end_check: monitor did not run final checks");
      $fatal(1, "end check not reached");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
